// File: rtl/hist_pkg.sv
// Shared types and constants for the histogram run controller.
package hist_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    RUN     = 3'd2,
    DRAIN   = 3'd3,
    READOUT = 3'd4,
    DONE    = 3'd5
  } hist_state_e;

  localparam int NBINS   = 256;
  localparam int MIN_DIV = 2;

endpackage

// File: rtl/hist_readout_skid.sv
// One-entry output register for the readout stream: holds a beat until accepted.
module hist_readout_skid #(
  parameter int NUM_OUT = 8,
  parameter int HIST_W  = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic [NUM_OUT-1:0] bin_i,
  input  logic [HIST_W-1:0]  count_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [NUM_OUT-1:0] bin_o,
  output logic [HIST_W-1:0]  count_o,
  output logic               last_o
);

  // Handshake: a beat transfers on a rising edge where valid_o && ready_i;
  // while valid_o && !ready_i every output is held unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_o <= 1'b0;
      bin_o   <= '0;
      count_o <= '0;
      last_o  <= 1'b0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      bin_o   <= bin_i;
      count_o <= count_i;
      last_o  <= &bin_i;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end
  end

endmodule

// File: rtl/hist_run_controller.sv
// Histogram run sequencer: clear RAM, accumulate samples by read-modify-write, stream bins out.
module hist_run_controller
  import hist_pkg::*;
#(
  parameter int NUM_OUT = 8,
  parameter int HIST_W  = 32,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W-1:0]   run_len,
  input  logic [7:0]         sample_div,
  input  logic [NUM_OUT-1:0] p_bits,
  output logic [NUM_OUT-1:0] mem_addr,
  output logic               mem_we,
  output logic [HIST_W-1:0]  mem_wdata,
  input  logic [HIST_W-1:0]  mem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] out_bin,
  output logic [HIST_W-1:0]  out_count,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic [2:0]         dbg_state
);

  hist_state_e        state_q, state_d;
  logic [NUM_OUT-1:0] addr_q, addr_d;
  logic [NUM_OUT-1:0] rmw_addr_q, rmw_addr_d;
  logic               rmw_pend_q, rmw_pend_d;
  logic               rd_vld_q, rd_vld_d;
  logic [CNT_W-1:0]   run_len_q, run_len_d;
  logic [CNT_W-1:0]   smp_cnt_q, smp_cnt_d;
  logic [7:0]         div_q, div_d;
  logic [7:0]         div_cnt_q, div_cnt_d;
  logic               skid_load, skid_flush;
  logic [HIST_W-1:0]  inc_data;

  assign inc_data  = (&mem_rdata) ? mem_rdata : mem_rdata + HIST_W'(1);
  assign busy      = (state_q == CLEAR) || (state_q == RUN) ||
                     (state_q == DRAIN) || (state_q == READOUT);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rmw_addr_q <= '0;
      rmw_pend_q <= 1'b0;
      rd_vld_q   <= 1'b0;
      run_len_q  <= '0;
      smp_cnt_q  <= '0;
      div_q      <= '0;
      div_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rmw_addr_q <= rmw_addr_d;
      rmw_pend_q <= rmw_pend_d;
      rd_vld_q   <= rd_vld_d;
      run_len_q  <= run_len_d;
      smp_cnt_q  <= smp_cnt_d;
      div_q      <= div_d;
      div_cnt_q  <= div_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rmw_addr_d = rmw_addr_q;
    rmw_pend_d = 1'b0;
    rd_vld_d   = 1'b0;
    run_len_d  = run_len_q;
    smp_cnt_d  = smp_cnt_q;
    div_d      = div_q;
    div_cnt_d  = div_cnt_q;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    skid_load  = 1'b0;
    skid_flush = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = CLEAR;
          addr_d    = '0;
          run_len_d = run_len;
          div_d     = (sample_div < 8'(MIN_DIV)) ? 8'(MIN_DIV) : sample_div;
          smp_cnt_d = '0;
          div_cnt_d = '0;
        end
      end
      CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = addr_q;
        addr_d   = addr_q + NUM_OUT'(1);
        if (&addr_q) state_d = (run_len_q != '0) ? RUN : READOUT;
      end
      RUN: begin
        if (rmw_pend_q) begin
          mem_we    = 1'b1;
          mem_addr  = rmw_addr_q;
          mem_wdata = inc_data;
        end
        // The divider guarantees a strobe never lands on the write cycle.
        if (div_cnt_q == 8'd0) begin
          mem_addr   = p_bits;
          rmw_addr_d = p_bits;
          rmw_pend_d = 1'b1;
          smp_cnt_d  = smp_cnt_q + CNT_W'(1);
          div_cnt_d  = div_q - 8'd1;
          if (smp_cnt_q + CNT_W'(1) == run_len_q) state_d = DRAIN;
        end else begin
          div_cnt_d = div_cnt_q - 8'd1;
        end
      end
      DRAIN: begin
        mem_we    = rmw_pend_q;
        mem_addr  = rmw_addr_q;
        mem_wdata = inc_data;
        addr_d    = '0;
        state_d   = READOUT;
      end
      READOUT: begin
        mem_addr = addr_q;
        if (rd_vld_q) begin
          skid_load = 1'b1;
        end else if (out_valid && out_ready) begin
          if (out_last) begin
            state_d = DONE;
          end else begin
            addr_d   = addr_q + NUM_OUT'(1);
            mem_addr = addr_q + NUM_OUT'(1);
            rd_vld_d = 1'b1;
          end
        end else if (!out_valid) begin
          rd_vld_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d    = IDLE;
      rmw_pend_d = 1'b0;
      rd_vld_d   = 1'b0;
      mem_we     = 1'b0;
      skid_load  = 1'b0;
      skid_flush = 1'b1;
    end
  end

  hist_readout_skid #(
    .NUM_OUT(NUM_OUT),
    .HIST_W (HIST_W)
  ) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (skid_load),
    .flush_i (skid_flush),
    .bin_i   (addr_q),
    .count_i (mem_rdata),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .bin_o   (out_bin),
    .count_o (out_count),
    .last_o  (out_last)
  );

endmodule

// File: doc/hist_run_controller.md
Name: hist_run_controller

Overview:
- Sequencer for one p-bit histogram run. Clears the histogram RAM, then accumulates p-bit output vectors into it for a programmed number of samples using read-modify-write.
- Freezes when the run ends, then streams every bin out over a valid/ready interface.
- Sits between the p-circuit output bus and a single-port histogram RAM. Owns that RAM's only port, so accumulate, clear and readout never collide.

Parameters:
- NUM_OUT, 8, p-bit vector width; number of bins NBINS = 2**NUM_OUT.
- HIST_W, 32, bin counter width.
- CNT_W, 32, width of the run-length and sample counters.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a run. Honoured only in IDLE or DONE.
- abort  in  1  level; forces IDLE.
- run_len  in  CNT_W  samples per run; captured on start.
- sample_div  in  8  sample spacing in cycles; captured on start; values 0, 1 and 2 all mean 2.
- p_bits  in  NUM_OUT  p-circuit output vector, sampled as is.
- mem_addr  out  NUM_OUT  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  HIST_W  RAM write data.
- mem_rdata  in  HIST_W  RAM read data, valid 1 cycle after the address is driven.
- out_valid  out  1  readout beat valid.
- out_ready  in  1  readout beat accepted when asserted together with out_valid.
- out_bin  out  NUM_OUT  bin index of the current beat.
- out_count  out  HIST_W  bin count of the current beat.
- out_last  out  1  asserted on the beat for bin NBINS-1.
- busy  out  1  high in CLEAR, RUN, DRAIN and READOUT.
- done  out  1  high in DONE (LED drive).

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- States: IDLE, CLEAR, RUN, DRAIN, READOUT, DONE.
- IDLE/DONE -> CLEAR on start. run_len and the effective divider div_eff = max(sample_div, 2) are latched in that cycle.
- CLEAR:
  - One bin per cycle: mem_we=1, mem_wdata=0, mem_addr=0..NBINS-1.
  - After bin NBINS-1 -> RUN if run_len != 0, else -> READOUT.
  - Duration is exactly NBINS cycles.
- RUN:
  - A sample strobe fires on the first RUN cycle and every div_eff cycles after it.
  - Strobe cycle t: p_bits is registered as A; mem_addr=A; mem_we=0.
  - Cycle t+1: mem_we=1, mem_addr=A, mem_wdata = mem_rdata+1.
  - The write saturates at all-ones: a bin holding 2**HIST_W-1 is not incremented.
  - div_eff >= 2 guarantees the write completes before the next read, so no forwarding is needed.
  - After the strobe that makes the sample count equal run_len -> DRAIN.
- DRAIN: issues the final write, then -> READOUT the next cycle.
- READOUT:
  - Bins are read in order 0..NBINS-1.
  - Drive address i; one cycle later load out_count=mem_rdata, out_bin=i, out_valid=1.
  - Hold all out_* stable while out_valid && !out_ready.
  - On acceptance, issue the read for i+1. This gives at most one beat per 2 cycles.
  - Accepting the beat with out_last=1 -> DONE; out_valid drops the next cycle.
  - mem_we=0 throughout READOUT.
- DONE: holds done=1 until start (new run, done cleared in the CLEAR entry cycle) or abort.
- abort, from any state:
  - Next cycle state=IDLE, mem_we=0, out_valid=0.
  - A pending RMW write is dropped and the bin contents are undefined; the next run's CLEAR repairs this.
  - abort and start in the same cycle: abort wins.
- start outside IDLE/DONE is ignored.
- The sample counter is CNT_W wide and never wraps; run_len=2**CNT_W-1 is legal.
- p_bits is captured only on strobe cycles; glitches between strobes do not matter.

Decomposition:
- Shared package hist_pkg:
  - state enum hist_state_e (IDLE, CLEAR, RUN, DRAIN, READOUT, DONE);
  - localparam NBINS;
  - MIN_DIV=2.
- Natural sub-module: hist_readout_skid. One-entry output register implementing the valid/ready hold and last generation. It keeps the top-level FSM to address sequencing only.

Test Plan:
1. Reset mid-RUN -> all outputs 0 within the reset assertion, state IDLE; a fresh start clears all 256 bins (mem_we high for exactly 256 cycles).
2. NUM_OUT=8, p_bits held at 0x5A, run_len=10, sample_div=4 -> readout has bin 0x5A = 10, all other bins 0, 256 beats, out_last only on bin 255.
3. sample_div=0, run_len=1000, p_bits driven by a counter mod 4 that updates each strobe -> bins 0..3 = 250 each; strobes exactly 2 cycles apart.
4. out_ready toggled 1-0-0-1 randomly during readout -> no beat lost or duplicated, out_* stable while stalled, sum of counts = run_len.
5. Model RAM preloaded so bin 3 = 0xFFFFFFFE, CLEAR bypassed by force, 3 samples of 3 -> bin 3 ends at 0xFFFFFFFF (saturated).
6. abort asserted in the DRAIN cycle together with start -> IDLE next cycle, mem_we=0, done=0; a later start completes normally with correct counts.
